// File: rtl/fir_tap_sequencer.sv
`default_nettype none
// fir_tap_sequencer: delay-line RAM sequencer that streams NTAPS taps (newest first) per accepted sample.
// Rev 1.0
module fir_tap_sequencer #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 7,
  parameter int NTAPS  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              clr,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_tap,
  output logic              m_last,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic              ram_reset,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_K  = ADDR_W'(NTAPS - 1);
  localparam logic [ADDR_W-1:0] LAST_AD = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] AD_ONE  = ADDR_W'(1);

  localparam logic [2:0] ST_CLEAR = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  logic [2:0]        state_q,    state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_W-1:0] wptr_q,     wptr_d;
  logic [ADDR_W-1:0] k_q,        k_d;
  logic              clr_pend_q, clr_pend_d;
  logic              m_valid_q,  m_valid_d;
  logic [ADDR_W-1:0] m_tap_q,    m_tap_d;
  logic              m_last_q,   m_last_d;
  logic              ram_ce_q,   ram_ce_d;
  logic              ram_wre_q,  ram_wre_d;
  logic [ADDR_W-1:0] ram_ad_q,   ram_ad_d;
  logic [DATA_W-1:0] ram_din_q,  ram_din_d;
  logic              clear_done;

  // The last zero write is the one currently presented at the RAM port.
  assign clear_done = ram_ce_q && ram_wre_q && (ram_ad_q == LAST_AD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      wptr_q     <= '0;
      k_q        <= '0;
      clr_pend_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_tap_q    <= '0;
      m_last_q   <= 1'b0;
      ram_ce_q   <= 1'b0;
      ram_wre_q  <= 1'b0;
      ram_ad_q   <= '0;
      ram_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      wptr_q     <= wptr_d;
      k_q        <= k_d;
      clr_pend_q <= clr_pend_d;
      m_valid_q  <= m_valid_d;
      m_tap_q    <= m_tap_d;
      m_last_q   <= m_last_d;
      ram_ce_q   <= ram_ce_d;
      ram_wre_q  <= ram_wre_d;
      ram_ad_q   <= ram_ad_d;
      ram_din_q  <= ram_din_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clear_done) state_d = ST_IDLE;
      ST_IDLE: begin
        if (s_valid)  state_d = ST_WRITE;
        else if (clr) state_d = ST_CLEAR;
      end
      ST_WRITE: state_d = ST_READ;
      ST_READ:  if (k_q == LAST_K) state_d = ST_DRAIN;
      ST_DRAIN: state_d = (clr_pend_q || clr) ? ST_CLEAR : ST_IDLE;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // RAM controls are registered from the next state so each access lines up
  // with the state that owns it.
  always_comb begin
    clr_addr_d = clr_addr_q;
    wptr_d     = wptr_q;
    k_d        = k_q;
    clr_pend_d = clr_pend_q;
    ram_ce_d   = 1'b0;
    ram_wre_d  = 1'b0;
    ram_ad_d   = ram_ad_q;
    ram_din_d  = ram_din_q;
    m_valid_d  = (state_q == ST_READ);
    m_tap_d    = (state_q == ST_READ) ? k_q : m_tap_q;
    m_last_d   = (state_q == ST_READ) && (k_q == LAST_K);

    if (clr && (state_q != ST_CLEAR)) clr_pend_d = 1'b1;
    if (state_q == ST_DRAIN)          wptr_d     = wptr_q + AD_ONE;

    case (state_d)
      ST_CLEAR: begin
        ram_ce_d   = 1'b1;
        ram_wre_d  = 1'b1;
        ram_din_d  = '0;
        clr_pend_d = 1'b0;
        wptr_d     = '0;
        if (state_q == ST_CLEAR) begin
          ram_ad_d   = clr_addr_q;
          clr_addr_d = clr_addr_q + AD_ONE;
        end else begin
          ram_ad_d   = '0;
          clr_addr_d = AD_ONE;
        end
      end
      ST_WRITE: begin
        ram_ce_d  = 1'b1;
        ram_wre_d = 1'b1;
        ram_ad_d  = wptr_q;
        ram_din_d = s_data;
      end
      ST_READ: begin
        k_d      = (state_q == ST_READ) ? (k_q + AD_ONE) : '0;
        ram_ce_d = 1'b1;
        ram_ad_d = wptr_q - k_d;
      end
      default: ;
    endcase
  end

  assign s_ready   = (state_q == ST_IDLE);
  assign m_valid   = m_valid_q;
  assign m_data    = ram_dout;
  assign m_tap     = m_tap_q;
  assign m_last    = m_last_q;
  assign ram_ce    = ram_ce_q;
  assign ram_oce   = 1'b1;
  assign ram_wre   = ram_wre_q;
  assign ram_reset = 1'b0;
  assign ram_ad    = ram_ad_q;
  assign ram_din   = ram_din_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_sequencer.sv
`default_nettype none
// tb_fir_tap_sequencer: randomized scoreboard bench with a sample-history reference model.
module tb_fir_tap_sequencer;
  localparam int DATA_W = 18;
  localparam int ADDR_W = 7;
  localparam int NTAPS  = 16;
  localparam int DEPTH  = 128;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              s_valid, s_ready, clr;
  logic [DATA_W-1:0] s_data;
  logic              m_valid, m_last;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_tap;
  logic              ram_ce, ram_oce, ram_wre, ram_reset;
  logic [ADDR_W-1:0] ram_ad;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  always #5 clk = ~clk;

  fir_tap_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NTAPS(NTAPS)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .clr(clr),
    .m_valid(m_valid), .m_data(m_data), .m_tap(m_tap), .m_last(m_last),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre), .ram_reset(ram_reset),
    .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single-port RAM, 1-cycle read latency, write-through; starts full of garbage.
  logic [DATA_W-1:0] mem [DEPTH];
  bit                filled = 1'b0;
  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'($urandom);
      ram_dout <= DATA_W'($urandom);
      filled   <= 1'b1;
    end else if (ram_ce) begin
      if (ram_wre) begin
        mem[ram_ad] <= ram_din;
        ram_dout    <= ram_din;
      end else begin
        ram_dout <= mem[ram_ad];
      end
    end
  end

  typedef struct {
    logic [DATA_W-1:0] data;
    int                tap;
    bit                last;
  } exp_t;

  exp_t              sbq[$];
  logic [DATA_W-1:0] hist[$];
  exp_t              mon_e;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = -1;
  bit spacing_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Tap k of a sample is the k-th most recent sample accepted since the last clear, else 0.
  task automatic model_accept(input logic [DATA_W-1:0] x);
    exp_t e;
    hist.push_back(x);
    for (int k = 0; k < NTAPS; k++) begin
      e.tap  = k;
      e.last = (k == NTAPS - 1);
      e.data = (k < hist.size()) ? hist[hist.size() - 1 - k] : '0;
      sbq.push_back(e);
    end
  endtask

  task automatic model_clear();
    hist.delete();
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (m_valid) begin
        if (sbq.size() == 0) begin
          check_eq("spurious_m_valid", m_valid, 0);
        end else begin
          mon_e = sbq.pop_front();
          check_eq("m_data", m_data, mon_e.data);
          check_eq("m_tap", m_tap, mon_e.tap);
          check_eq("m_last", m_last, mon_e.last);
        end
      end
      if (s_ready) check_eq("ram_ce_in_idle", ram_ce, 0);
    end
  end

  task automatic push(input logic [DATA_W-1:0] x, input bit with_clr);
    int n = 0;
    @(negedge clk);
    clr     = 1'b0;
    s_valid = 1'b1;
    s_data  = x;
    while (!s_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      check_eq("accept_timeout", s_ready, 1);
      s_valid = 1'b0;
      return;
    end
    clr = with_clr;
    model_accept(x);
    if (with_clr) model_clear();
    if (spacing_chk && last_acc >= 0) check_eq("accept_spacing", cyc - last_acc, NTAPS + 3);
    last_acc = cyc;
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_queue", sbq.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_tap(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_valid && m_tap == k) && n < 200);
    check_eq("wait_tap_found", m_tap, k);
  endtask

  // Watches a full clear sequence; optionally pulses clr mid-clear, which must be ignored.
  task automatic clear_watch(input int glitch);
    int n = 0;
    int wr = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      clr = (n == glitch);
      if (clr) model_clear();
      if (ram_ce && ram_wre) begin
        check_eq("clear_addr", ram_ad, wr);
        check_eq("clear_din", ram_din, 0);
        wr++;
      end
      if (s_ready) break;
    end
    clr = 1'b0;
    check_eq("clear_cycles_to_ready", n, DEPTH + 1);
    check_eq("clear_write_count", wr, DEPTH);
  endtask

  task automatic reset_checks();
    check_eq("rst_s_ready", s_ready, 0);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_m_tap", m_tap, 0);
    check_eq("rst_m_last", m_last, 0);
    check_eq("rst_ram_ce", ram_ce, 0);
    check_eq("rst_ram_wre", ram_wre, 0);
    check_eq("rst_ram_ad", ram_ad, 0);
    check_eq("rst_ram_din", ram_din, 0);
    check_eq("ram_oce", ram_oce, 1);
    check_eq("ram_reset", ram_reset, 0);
  endtask

  initial begin
    reset_n = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    clr     = 1'b0;
    #3 reset_n = 1'b0;
    #1 reset_checks();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    clear_watch(0);

    // Three samples back to back
    spacing_chk = 1'b1;
    last_acc    = -1;
    push(18'd1, 1'b0);
    push(18'd2, 1'b0);
    push(18'd3, 1'b0);
    idle();
    wait_drain();

    // Clear from idle, with a clr pulse during the clear that must not restart it
    @(negedge clk);
    clr = 1'b1;
    model_clear();
    clear_watch(50);

    // Ramp long enough to wrap the write pointer
    last_acc = -1;
    for (int i = 0; i < 130; i++) push(DATA_W'(i), 1'b0);
    idle();
    wait_drain();
    spacing_chk = 1'b0;

    // clr during READ completes current taps, then clears
    push(18'h2A5A5, 1'b0);
    idle();
    wait_tap(3);
    clr = 1'b1;
    model_clear();
    @(negedge clk);
    clr = 1'b0;
    wait_drain();
    push(18'h01234, 1'b0);
    idle();
    wait_drain();

    // Handshake and clr in the same idle cycle
    push(18'h3C3C3, 1'b1);
    idle();
    wait_drain();
    push(18'h00077, 1'b0);
    idle();
    wait_drain();

    // Randomized traffic with sporadic clears
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      s_valid = ($urandom % 3) != 0;
      s_data  = DATA_W'($urandom);
      clr     = ($urandom % 60) == 0;
      if (s_valid && s_ready) model_accept(s_data);
      if (clr) model_clear();
    end
    idle();
    wait_drain();

    // Asynchronous reset in the middle of a read burst
    push(18'h15555, 1'b0);
    idle();
    push(18'h0AAAA, 1'b0);
    idle();
    wait_tap(4);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midread_m_valid", m_valid, 0);
    check_eq("midread_m_tap", m_tap, 0);
    check_eq("midread_ram_ce", ram_ce, 0);
    check_eq("midread_ram_ad", ram_ad, 0);
    sbq.delete();
    model_clear();
    repeat (3) @(negedge clk);
    check_eq("reset_hold_m_valid", m_valid, 0);
    reset_n = 1'b1;
    clear_watch(0);
    push(18'h2F00F, 1'b0);
    idle();
    wait_drain();

    check_eq("final_queue_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/fir_tap_sequencer.md
FIR_TAP_SEQUENCER -- requirements
Module: fir_tap_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 18, sample/RAM word width.
REQ-002 SHALL have parameter ADDR_W, default 7, RAM address width; DEPTH = 2**ADDR_W = 128.
REQ-003 SHALL have parameter NTAPS, default 16, taps read per sample; legal range 2..DEPTH.
REQ-004 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port s_valid  in  1  input sample valid.
REQ-007 SHALL have port s_ready  out  1  input sample accepted when s_valid & s_ready.
REQ-008 SHALL have port s_data  in  DATA_W  input sample.
REQ-009 SHALL have port clr  in  1  request to zero the delay line.
REQ-010 SHALL have port m_valid  out  1  tap sample valid (no backpressure).
REQ-011 SHALL have port m_data  out  DATA_W  tap sample, driven directly from ram_dout.
REQ-012 SHALL have port m_tap  out  ADDR_W  tap index k (0 = newest).
REQ-013 SHALL have port m_last  out  1  high with m_valid when k = NTAPS-1.
REQ-014 SHALL have ports ram_ce, ram_oce, ram_wre, ram_reset  out  1 each  single-port RAM controls.
REQ-015 SHALL have ports ram_ad  out  ADDR_W; ram_din  out  DATA_W; ram_dout  in  DATA_W (RAM read latency 1 cycle, bypass mode).

Function
REQ-016 SHALL register all ram_* outputs; ram_oce constant 1; ram_reset constant 0.
REQ-017 SHALL implement FSM states CLEAR, IDLE, WRITE, READ, DRAIN.
REQ-018 CLEAR: ram_ce=1, ram_wre=1, ram_din=0, ram_ad counts 0..DEPTH-1, one address per cycle; after address DEPTH-1 -> IDLE; s_ready=0.
REQ-019 IDLE: s_ready=1 (combinational from state, not from s_valid); on handshake capture s_data, -> WRITE; else if clr=1 -> CLEAR; handshake has priority over clr in the same cycle, clr then held pending.
REQ-020 WRITE (one cycle): ram_ce=1, ram_wre=1, ram_ad=wptr, ram_din=captured sample -> READ.
REQ-021 READ (NTAPS cycles, k=0..NTAPS-1): ram_ce=1, ram_wre=0, ram_ad=(wptr-k) mod DEPTH; after k=NTAPS-1 -> DRAIN.
REQ-022 DRAIN (one cycle): ram_ce=0; wptr <= (wptr+1) mod DEPTH; -> CLEAR if clr pending, else IDLE.
REQ-023 m_valid SHALL be high exactly one cycle after each READ cycle, with m_tap=k and m_data=ram_dout of that read.
REQ-024 Timing: handshake at cycle T -> WRITE at T+1, reads T+2..T+1+NTAPS, m_valid T+3..T+2+NTAPS, s_ready again at T+3+NTAPS; throughput 1 sample / (NTAPS+3) cycles.
REQ-025 Tap k=0 SHALL return the sample written in the immediately preceding WRITE cycle.
REQ-026 wptr SHALL wrap DEPTH-1 -> 0; read address subtraction SHALL wrap modulo DEPTH.
REQ-027 Taps older than samples written since last CLEAR SHALL read 0.
REQ-028 clr asserted outside IDLE SHALL be latched and serviced at DRAIN exit; CLEAR SHALL reset wptr to 0 and drop pending clr.
REQ-029 clr asserted during CLEAR SHALL be ignored (no restart).
REQ-030 ram_ce=0 in IDLE and DRAIN; no RAM access outside REQ-018..021.

Reset
REQ-031 On reset_n=0 SHALL asynchronously force: state=CLEAR, clear address=0, wptr=0, clr pending=0, s_ready=0, m_valid=0, m_tap=0, m_last=0, ram_ce=0, ram_wre=0, ram_ad=0, ram_din=0.
REQ-032 After reset_n release SHALL perform full CLEAR (DEPTH cycles) before first s_ready=1.
REQ-033 Reset mid-READ SHALL abort with no further m_valid pulses.

Verification
REQ-034 Reset release -> 128 zero writes ad 0..127, then s_ready=1 at cycle 129 after release.
REQ-035 Push samples 1,2,3 (NTAPS=16) -> third sample yields m_data 3,2,1,0,...,0, m_tap 0..15, m_last on tap 15, 19 cycles between accepts.
REQ-036 Push 130 samples value=index -> wptr wraps; for last sample taps read 129,128,...,114.
REQ-037 Assert clr during READ -> current taps complete unchanged, then CLEAR; next sample X yields X then 15 zeros.
REQ-038 s_valid and clr same IDLE cycle -> sample processed first, then CLEAR.
REQ-039 reset_n low during READ at k=5 -> m_valid low asynchronously, CLEAR restarts on release.
